// File: rtl/divisor_sequencial.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Unsigned or two's-complement operands; flags divide-by-zero and overflow.
module divisor_sequencial #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             err,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   b_q, b_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] araw_q, araw_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic             dz_q, dz_d;
  logic             ovfp_q, ovfp_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             smode;
  logic [WIDTH:0]   a_ext, b_ext;
  logic [WIDTH:0]   a_mag, b_mag;
  logic [WIDTH:0]   p;
  logic [WIDTH+1:0] t;
  logic [WIDTH-1:0] rmag;
  logic             unused_bits;

  always_comb begin
    smode = SIGNED_EN & signed_mode;
    a_ext = {smode & dividend[WIDTH-1], dividend};
    b_ext = {smode & divisor[WIDTH-1], divisor};
    // Extra bit keeps the most-negative value's magnitude representable
    a_mag = a_ext[WIDTH] ? -a_ext : a_ext;
    b_mag = b_ext[WIDTH] ? -b_ext : b_ext;
    p     = {r_q[WIDTH-1:0], a_q[cnt_q]};
    t     = {1'b0, p} - {1'b0, b_q};
    rmag  = r_q[WIDTH-1:0];
    unused_bits = r_q[WIDTH];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    q_d         = q_q;
    araw_d      = araw_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    dz_d        = dz_q;
    ovfp_d      = ovfp_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The done cycle is still IDLE but must not accept
        if (start && !done_q) begin
          a_d      = a_mag;
          b_d      = b_mag;
          r_d      = '0;
          q_d      = '0;
          araw_d   = dividend;
          cnt_d    = CW'(WIDTH - 1);
          sign_q_d = a_ext[WIDTH] ^ b_ext[WIDTH];
          sign_r_d = a_ext[WIDTH];
          dz_d     = (divisor == '0);
          ovfp_d   = smode
                     && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                     && (divisor == '1);
          state_d  = (divisor == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (!t[WIDTH+1]) begin
          r_d = t[WIDTH:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = p;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FINISH;
      end
      FINISH: begin
        done_d = 1'b1;
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = araw_q;
          err_d       = 1'b1;
          ovf_d       = 1'b0;
        end else begin
          quotient_d  = sign_q_q ? -q_q : q_q;
          remainder_d = sign_r_q ? -rmag : rmag;
          err_d       = 1'b0;
          ovf_d       = ovfp_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      araw_q      <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      dz_q        <= 1'b0;
      ovfp_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      q_q         <= q_d;
      araw_q      <= araw_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      dz_q        <= dz_d;
      ovfp_q      <= ovfp_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/divisor_sequencial.md
Name: divisor_sequencial

Overview:
- Parametrised, multi-cycle restoring divider. It is the sequential successor to the 4-bit combinational divider.
- Computes one quotient bit per clock. Supports unsigned and signed (two's complement) operands.
- Uses a start/busy/done handshake. Flags divide-by-zero and signed overflow.
- Sits in the ALU datapath beside the adder and multiplier. Results are registered and held until the next operation.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- SIGNED_EN, 1, 1 = signed_mode input honoured; 0 = signed_mode ignored and the block is always unsigned.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = operands are two's complement; sampled with start.
- dividend  in  WIDTH  dividend A; sampled with start.
- divisor  in  WIDTH  divisor B; sampled with start.
- busy  out  1  high from the accepting edge until the done edge.
- done  out  1  one-cycle pulse when results become valid.
- quotient  out  WIDTH  registered quotient.
- remainder  out  WIDTH  registered remainder.
- err  out  1  divide-by-zero flag for the last operation.
- ovf  out  1  signed overflow flag (most-negative / −1) for the last operation.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, quotient=0, remainder=0, err=0, ovf=0; internal counter and registers cleared.
- States: IDLE, RUN, FINISH.
- IDLE → RUN: at edge N with start=1. Latch operands and mode; busy=1 after edge N.
- IDLE → FINISH: at edge N if divisor==0.
- Signed preprocessing at load: latch |A| and |B| (WIDTH+1-bit internal magnitudes, so the most-negative value is safe). Record sign_q = sA^sB and sign_r = sA.
- RUN: WIDTH iterations, edges N+1..N+WIDTH, MSB first.
  - Each iteration: P = {R[WIDTH-1:0], next A bit}, computed at WIDTH+1 bits. T = P − {0,B}.
  - If T is non-negative: q bit = 1, R = T. Otherwise: q bit = 0, R = P (restore).
  - Counter counts WIDTH−1 down to 0; RUN → FINISH after the iteration with counter==0.
- FINISH (one cycle): register outputs at edge N+WIDTH+1 (N+1 for divide-by-zero). done=1 and busy=0 during the following cycle. Return to IDLE.
- Signed results: quotient truncates toward zero (negated if sign_q). Remainder takes the sign of the dividend (negated if sign_r). Remainder magnitude is always < |B|.
- Divide by zero: quotient = all ones, remainder = dividend unchanged, err=1, ovf=0. Latency is 1 cycle.
- Signed overflow (A = −2^(WIDTH−1), B = −1): quotient = A (wraps), remainder = 0, ovf=1, err=0. Full WIDTH-cycle latency.
- err and ovf are updated only on the done edge and held until the next done.
- quotient and remainder hold their value between operations. They are never X after reset.
- start while busy: ignored, not queued.
- start in the same cycle done is high: ignored. The block accepts only in IDLE, i.e. on the cycle after done.
- Inputs may change freely after the accepting edge without affecting the operation.
- Reset mid-operation: the operation is aborted immediately. No done pulse; outputs return to reset values.
- Latency: unsigned and signed nonzero operations are WIDTH+1 cycles from the accepting edge to done. Throughput is one operation per WIDTH+2 cycles.

Test Plan:
- WIDTH=8, unsigned, A=200, B=7 → after 9 cycles: done=1 for one cycle, quotient=28 (0x1C), remainder=4, err=0, ovf=0; busy high for exactly 9 cycles.
- Signed, A=0x9C (−100), B=0x07 → quotient=0xF2 (−14), remainder=0xFE (−2). Also check A=100, B=−7 → quotient=0xF2, remainder=0x02.
- A=13, B=0 → done 1 cycle after the accepting edge; quotient=0xFF, remainder=0x0D, err=1. The next valid operation clears err.
- Signed, A=0x80, B=0xFF → quotient=0x80, remainder=0x00, ovf=1, err=0, latency 9 cycles.
- Start pulsed again during RUN with different operands → ignored; first result correct, only one done pulse.
- rst asserted at iteration 4 of 200/7 → outputs 0 asynchronously, no done. A new 255/16 after reset → quotient=15, remainder=15.
- Random sweep: all 4-bit pairs with WIDTH=4 compared against a reference model, both modes.
